// File: rtl/trig_series_accelerator.sv
// Sequential truncated-Taylor sin/cos engine: one series term per clock, shared term register.
// Latency N+1 cycles start->done; start is ignored unless ready (no queueing).
module trig_series_accelerator #(
  parameter int W         = 10,
  parameter int CW        = 12,
  parameter int MAX_TERMS = 8,
  localparam int NW       = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  x,
  input  logic [NW-1:0] n_terms,
  output logic [W:0]    result,
  output logic          ready,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

  localparam int ROM_N = 2 ** NW;
  localparam logic [W:0] ONE_T = (W + 1)'(1) << W;
  localparam logic signed [W+2:0] ONE_S = (W + 3)'(1) << W;

  // round(2^CW / n!); the factorial stops growing once the quotient is certainly zero.
  function automatic logic [CW:0] recip_fact(input int n);
    longint f;
    f = 1;
    for (int i = 2; i <= n; i++) begin
      if (f <= (longint'(1) << (CW + 2))) f = f * i;
    end
    return (CW + 1)'(((longint'(1) << (CW + 1)) + f) / (2 * f));
  endfunction

  logic [CW:0] cos_rom [ROM_N];
  logic [CW:0] sin_rom [ROM_N];

  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    localparam logic [CW:0] C_COS = (g < MAX_TERMS) ? recip_fact(2 * g)     : '0;
    localparam logic [CW:0] C_SIN = (g < MAX_TERMS) ? recip_fact(2 * g + 1) : '0;
    assign cos_rom[g] = C_COS;
    assign sin_rom[g] = C_SIN;
  end

  state_t                state_q;
  logic                  mode_q;
  logic [W-1:0]          x_q;
  logic [NW-1:0]         n_q;
  logic [NW-1:0]         k_q;
  logic [W:0]            x2_q;
  logic [W:0]            t_q;
  logic signed [W+2:0]   acc_q;
  logic [W:0]            result_q;
  logic                  ready_q;
  logic                  done_q;

  logic [CW:0]           coef;
  logic [W+CW+1:0]       prod_tc;
  logic [2*W+1:0]        prod_tx;
  logic [2*W-1:0]        prod_xx;
  logic [W:0]            term;
  logic [W:0]            t_d;
  logic [W:0]            x2_d;
  logic signed [W+2:0]   term_s;
  logic signed [W+2:0]   acc_d;
  logic [W:0]            result_d;
  logic [NW-1:0]         n_d;
  logic                  last;

  assign coef    = mode_q ? sin_rom[k_q] : cos_rom[k_q];
  assign prod_tc = {{(CW + 1){1'b0}}, t_q} * {{(W + 1){1'b0}}, coef};
  assign prod_tx = {{(W + 1){1'b0}}, t_q} * {{(W + 1){1'b0}}, x2_q};
  assign prod_xx = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
  assign term    = (W + 1)'(prod_tc >> CW);
  assign t_d     = (W + 1)'(prod_tx >> W);
  assign x2_d    = (W + 1)'(prod_xx >> W);
  assign term_s  = signed'({2'b00, term});
  // Series signs alternate: even terms add, odd terms subtract.
  assign acc_d   = k_q[0] ? (acc_q - term_s) : (acc_q + term_s);
  assign last    = (k_q == n_q - 1'b1);

  always_comb begin
    result_d = acc_d[W:0];
    if (acc_d < 0)          result_d = '0;
    else if (acc_d > ONE_S) result_d = ONE_T;
  end

  always_comb begin
    n_d = n_terms;
    if (n_terms == '0)                 n_d = NW'(1);
    else if (n_terms > NW'(MAX_TERMS)) n_d = NW'(MAX_TERMS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      x_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      x2_q     <= '0;
      t_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            x_q     <= x;
            n_q     <= n_d;
            ready_q <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          x2_q    <= x2_d;
          t_q     <= mode_q ? {1'b0, x_q} : ONE_T;
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          t_q   <= t_d;
          k_q   <= k_q + 1'b1;
          if (last) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign done   = done_q;

endmodule

// File: tb/tb_trig_series_accelerator.sv
// Directed-vector and sweep bench for trig_series_accelerator (W=10, CW=12, MAX_TERMS=8).
module tb_trig_series_accelerator;
  localparam int W  = 10;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  x = '0;
  logic [NW-1:0] n_terms = '0;
  logic [W:0]    result;
  logic          ready;
  logic          done;

  int total = 0;
  int bad   = 0;

  trig_series_accelerator dut (
    .clk(clk), .rst(rst_n), .start(start), .mode(mode), .x(x),
    .n_terms(n_terms), .result(result), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m;
    int xv;
    int nv;
    int er;
    int el;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int coef(input bit m, input int k);
    case (k)
      0: return 4096;
      1: return m ? 683 : 2048;
      2: return m ? 34 : 171;
      3: return m ? 1 : 6;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_val(input bit m, input int xv, input int nv);
    int n, x2, t, acc, term;
    n   = (nv == 0) ? 1 : (nv > 8 ? 8 : nv);
    x2  = (xv * xv) >> 10;
    t   = m ? xv : 1024;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      term = (t * coef(m, k)) >> 12;
      acc  = (k % 2 == 1) ? acc - term : acc + term;
      t    = (t * x2) >> 10;
    end
    if (acc < 0) acc = 0;
    if (acc > 1024) acc = 1024;
    return acc;
  endfunction

  // Called at a negedge with the DUT ready; returns at the negedge where ready is back.
  task automatic run(input bit m, input int xv, input int nv,
                     output int res, output int lat, output int dones);
    for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
    start   = 1'b1;
    mode    = m;
    x       = W'(xv);
    n_terms = NW'(nv);
    @(negedge clk);
    start   = 1'b0;
    mode    = ~m;
    x       = W'($urandom);
    n_terms = NW'($urandom);
    lat   = 0;
    dones = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      lat++;
      if (done) dones++;
      @(negedge clk);
    end
    if (!ready) lat = 99;
    if (done) dones++;
    res = int'(result);
  endtask

  initial begin
    int res, lat, dones, rl;
    real rv;

    vecs[0] = '{0, 0,    4, 1024, 5};
    vecs[1] = '{1, 0,    4, 0,    5};
    vecs[2] = '{0, 512,  1, 1024, 2};
    vecs[3] = '{0, 512,  2, 896,  3};
    vecs[4] = '{0, 512,  4, 898,  5};
    vecs[5] = '{1, 512,  3, 491,  4};
    vecs[6] = '{1, 512,  0, 512,  2};
    vecs[7] = '{0, 512, 15, 898,  9};
    vecs[8] = '{1, 1023, 1, 1023, 2};
    vecs[9] = '{0, 1023, 1, 1024, 2};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done), 0);

    // Runs are issued back-to-back: each start lands on the completion cycle of the previous run.
    for (int i = 0; i < 10; i++) begin
      run(vecs[i].m, vecs[i].xv, vecs[i].nv, res, lat, dones);
      check($sformatf("vec%0d_result", i), res, vecs[i].er);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].el);
      check($sformatf("vec%0d_dones", i), dones, 1);
    end

    // start hammered while busy must not restart or queue a run
    start = 1'b1; mode = 1'b0; x = W'(512); n_terms = NW'(4);
    @(negedge clk);
    lat = 0; dones = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      lat++;
      if (done) dones++;
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    if (done) dones++;
    check("busy_result", int'(result), 898);
    check("busy_latency", lat, 5);
    check("busy_dones", dones, 1);
    @(negedge clk);
    check("busy_after_ready", int'(ready), 1);
    check("busy_after_done", int'(done), 0);

    // Reset in the middle of an N=8 run
    start = 1'b1; mode = 1'b0; x = W'(512); n_terms = NW'(8);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
      if (!ready) lat++;
    end
    check("abort_no_done", dones, 0);
    check("abort_stays_idle", lat, 0);
    run(1'b1, 512, 3, res, lat, dones);
    check("post_abort_result", res, 491);
    check("post_abort_latency", lat, 4);
    check("post_abort_dones", dones, 1);

    for (int xv = 0; xv < 1024; xv += 31) begin
      for (int m = 0; m < 2; m++) begin
        run(m[0], xv, 8, res, lat, dones);
        check($sformatf("sweep_m%0d_x%0d_model", m, xv), res, ref_val(m[0], xv, 8));
        check($sformatf("sweep_m%0d_x%0d_lat", m, xv), lat, 9);
        rv = (m == 1) ? $sin(real'(xv) / 1024.0) : $cos(real'(xv) / 1024.0);
        rl = $rtoi(rv * 1024.0 + 0.5);
        check($sformatf("sweep_m%0d_x%0d_within3", m, xv),
              int'(res - rl <= 3 && rl - res <= 3), 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
